// File: rtl/branch_decide_unit.sv
// Registered branch-decision stage: evaluates conditional branches/jumps, drives the
// PC select one cycle later, squashes wrong-path slots and keeps branch statistics.
module branch_decide_unit #(
  parameter int WIDTH        = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_valid,
  input  logic                 in_stall,
  input  logic [2:0]           in_op,
  input  logic [WIDTH-1:0]     in_rs,
  input  logic [WIDTH-1:0]     in_rt,
  input  logic                 in_clr_cnt,
  output logic                 out_valid,
  output logic                 out_taken,
  output logic                 out_cidi_control,
  output logic                 out_flush,
  output logic [CNT_WIDTH-1:0] out_branch_cnt,
  output logic [CNT_WIDTH-1:0] out_taken_cnt
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t     state_reg;
  logic [3:0] flush_cnt_reg;

  logic rs_sign, rs_zero, rs_eq_rt;
  logic taken_next, is_cond, accept;

  assign rs_sign  = in_rs[WIDTH-1];
  assign rs_zero  = (in_rs == '0);
  assign rs_eq_rt = (in_rs == in_rt);

  always_comb begin
    taken_next = 1'b0;
    case (in_op)
      3'b001:  taken_next = rs_eq_rt;
      3'b010:  taken_next = !rs_eq_rt;
      3'b011:  taken_next = !rs_sign;
      3'b100:  taken_next = rs_sign;
      3'b101:  taken_next = !rs_sign && !rs_zero;
      3'b110:  taken_next = rs_sign || rs_zero;
      3'b111:  taken_next = 1'b1;
      default: taken_next = 1'b0;
    endcase
  end

  assign is_cond = (in_op != 3'b000) && (in_op != 3'b111);
  assign accept  = in_valid && !in_stall && (state_reg == RUN);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg        <= RUN;
      flush_cnt_reg    <= '0;
      out_valid        <= 1'b0;
      out_taken        <= 1'b0;
      out_cidi_control <= 1'b1;
      out_flush        <= 1'b0;
      out_branch_cnt   <= '0;
      out_taken_cnt    <= '0;
    end else begin
      // Clear wins over any increment in the same cycle, and works even while stalled.
      if (in_clr_cnt) begin
        out_branch_cnt <= '0;
        out_taken_cnt  <= '0;
      end else if (accept && is_cond) begin
        if (out_branch_cnt != '1) out_branch_cnt <= out_branch_cnt + 1'b1;
        if (taken_next && (out_taken_cnt != '1)) out_taken_cnt <= out_taken_cnt + 1'b1;
      end

      if (!in_stall) begin
        out_valid        <= accept;
        out_taken        <= accept && taken_next;
        out_cidi_control <= !(accept && taken_next);
        case (state_reg)
          RUN: begin
            if (accept && taken_next) begin
              state_reg     <= FLUSH;
              flush_cnt_reg <= FLUSH_LOAD;
              out_flush     <= 1'b1;
            end
          end
          FLUSH: begin
            if (flush_cnt_reg == 4'd1) begin
              state_reg     <= RUN;
              flush_cnt_reg <= '0;
              out_flush     <= 1'b0;
            end else begin
              flush_cnt_reg <= flush_cnt_reg - 4'd1;
            end
          end
          default: state_reg <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_decide_unit.sv
// Scoreboard bench for branch_decide_unit: the driver pushes expected decisions,
// a negedge monitor pops and compares them whenever the DUT presents a new decision.
module tb_branch_decide_unit;

  localparam int WIDTH = 32;
  localparam int CNTW  = 4;
  localparam int FLUSH = 2;

  logic             clk = 1'b0;
  logic             rst, valid, stall, clr;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs, rt;
  logic             o_valid, o_taken, o_cidi, o_flush;
  logic [CNTW-1:0]  o_bcnt, o_tcnt;

  branch_decide_unit #(.WIDTH(WIDTH), .CNT_WIDTH(CNTW), .FLUSH_CYCLES(FLUSH)) dut (
    .in_clk(clk), .in_rst(rst), .in_valid(valid), .in_stall(stall), .in_op(op),
    .in_rs(rs), .in_rt(rt), .in_clr_cnt(clr),
    .out_valid(o_valid), .out_taken(o_taken), .out_cidi_control(o_cidi),
    .out_flush(o_flush), .out_branch_cnt(o_bcnt), .out_taken_cnt(o_tcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            tk;
    logic [CNTW-1:0] b;
    logic [CNTW-1:0] t;
  } exp_t;

  exp_t            q[$];
  int              n_chk  = 0;
  int              n_fail = 0;
  logic [CNTW-1:0] m_b = '0, m_t = '0;
  logic            hold_q = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A decision is only new when the edge that produced it was neither stalled nor reset.
  always @(posedge clk) hold_q <= stall | rst;

  always @(negedge clk) begin
    if (o_valid && !hold_q) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("taken", 32'(o_taken), 32'(e.tk));
        chk("cidi", 32'(o_cidi), 32'(!e.tk));
        chk("branch_cnt", 32'(o_bcnt), 32'(e.b));
        chk("taken_cnt", 32'(o_tcnt), 32'(e.t));
        $display("decision: taken=%0b cidi=%0b bcnt=%0d tcnt=%0d", o_taken, o_cidi, o_bcnt, o_tcnt);
      end
    end
  end

  // One clock of stimulus; exp_acc/exp_tk are the hand-computed decision for this vector.
  task automatic step(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic st, input logic c, input logic r, input logic exp_acc, input logic exp_tk);
    exp_t e;
    valid = v; op = o; rs = a; rt = b; stall = st; clr = c; rst = r;
    @(posedge clk);
    if (r) begin
      m_b = '0; m_t = '0;
    end else if (c) begin
      m_b = '0; m_t = '0;
    end else if (exp_acc && o != 3'b000 && o != 3'b111) begin
      if (m_b != '1) m_b = m_b + 1'b1;
      if (exp_tk && m_t != '1) m_t = m_t + 1'b1;
    end
    if (exp_acc && !r) begin
      e.tk = exp_tk; e.b = m_b; e.t = m_t;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic tk);
    step(1'b1, o, a, b, 1'b0, 1'b0, 1'b0, 1'b1, tk);
    if (tk) idle(FLUSH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    valid = 0; op = 0; rs = 0; rt = 0; stall = 0; clr = 0; rst = 1;
    @(negedge clk);
    // Reset held two cycles with busy inputs
    step(1'b1, 3'b111, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b001, 32'd3, 32'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_taken", 32'(o_taken), 32'd0);
    chk("rst_cidi", 32'(o_cidi), 32'd1);
    chk("rst_flush", 32'(o_flush), 32'd0);
    chk("rst_bcnt", 32'(o_bcnt), 32'd0);
    chk("rst_tcnt", 32'(o_tcnt), 32'd0);

    // First branch after reset, then the flush window timing
    step(1'b1, 3'b001, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_rise", 32'(o_flush), 32'd1);
    idle(1);
    chk("flush_hold", 32'(o_flush), 32'd1);
    idle(1);
    chk("flush_fall", 32'(o_flush), 32'd0);

    // Sign/zero boundaries; non-taken pair goes back-to-back
    step(1'b0, 3'b000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_bcnt", 32'(o_bcnt), 32'd0);
    issue(3'b011, 32'h0000_0000, 0, 1'b1);
    issue(3'b100, 32'h8000_0000, 0, 1'b1);
    issue(3'b101, 32'h0000_0000, 0, 1'b0);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(3'b110, 32'h0000_0000, 0, 1'b1);
    issue(3'b101, 32'h7FFF_FFFF, 0, 1'b1);
    chk("sign_bcnt", 32'(o_bcnt), 32'd6);
    chk("sign_tcnt", 32'(o_tcnt), 32'd4);

    // JMP opens flush; two valid BEQs squashed; third accepted
    step(1'b1, 3'b111, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 3'b001, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("squash1_flush", 32'(o_flush), 32'd1);
    chk("squash1_valid", 32'(o_valid), 32'd0);
    step(1'b1, 3'b001, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("squash2_flush", 32'(o_flush), 32'd0);
    chk("squash_bcnt", 32'(o_bcnt), 32'd6);
    issue(3'b001, 32'd1, 32'd1, 1'b1);
    chk("post_flush_bcnt", 32'(o_bcnt), 32'd7);

    // Stall mid-flush holds everything
    step(1'b1, 3'b010, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b001, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("stall_flush", 32'(o_flush), 32'd1);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_taken", 32'(o_taken), 32'd1);
      chk("stall_cidi", 32'(o_cidi), 32'd0);
      chk("stall_bcnt", 32'(o_bcnt), 32'd8);
    end
    idle(1);
    chk("unstall_flush1", 32'(o_flush), 32'd1);
    idle(1);
    chk("unstall_flush2", 32'(o_flush), 32'd0);
    // Clear still works while stalled
    step(1'b1, 3'b001, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_clr_bcnt", 32'(o_bcnt), 32'd0);
    chk("stall_clr_tcnt", 32'(o_tcnt), 32'd0);

    // Saturation at all-ones
    for (int i = 0; i < 17; i++) issue(3'b001, 32'(i), 32'(i), 1'b1);
    chk("sat_bcnt", 32'(o_bcnt), 32'd15);
    chk("sat_tcnt", 32'(o_tcnt), 32'd15);
    step(1'b1, 3'b010, 32'd3, 32'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_win_bcnt", 32'(o_bcnt), 32'd0);
    chk("clr_win_tcnt", 32'(o_tcnt), 32'd0);

    // Reset mid-flush, then immediate accept
    step(1'b1, 3'b111, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("pre_rst_flush", 32'(o_flush), 32'd1);
    step(1'b1, 3'b001, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_flush", 32'(o_flush), 32'd0);
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_cidi", 32'(o_cidi), 32'd1);
    issue(3'b001, 32'd4, 32'd4, 1'b1);
    chk("after_rst_bcnt", 32'(o_bcnt), 32'd1);

    idle(2);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
